// File: rtl/alu_issue_pkg.sv
// Shared ALU opcode encodings, issue-stage state encoding and payload types.
package alu_issue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 3;
  localparam int unsigned IMMW = 16;
  localparam int unsigned FW   = 3;
  localparam int unsigned RCW  = 16;

  typedef enum logic [CW-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HALT = 2'd2
  } issue_state_e;

  // Contents of the issue register feeding alu32.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [CW-1:0]   ctrl;
    logic [RW-1:0]   rd;
  } issue_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake and writeback bus between the issue stage and its producer.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_rs;
  logic [RW-1:0]   in_rt;
  logic [RW-1:0]   in_rd;
  logic [CW-1:0]   in_ctrl;
  logic            in_use_imm;
  logic [IMMW-1:0] in_imm;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [FW-1:0]   wb_flags;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_ctrl, in_use_imm, in_imm,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_flags
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_ctrl, in_use_imm, in_imm,
    output in_ready, wb_valid, wb_rd, wb_data, wb_flags
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two combinational read ports, a debug read port, one write port, r0 reads zero.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   ra_num,
  output logic [XLEN-1:0] ra_data_c,
  input  logic [RW-1:0]   rb_num,
  output logic [XLEN-1:0] rb_data_c,
  input  logic [RW-1:0]   dbg_num,
  output logic [XLEN-1:0] dbg_data_c,
  input  logic            we,
  input  logic [RW-1:0]   wr_num,
  input  logic [XLEN-1:0] wr_data
);

  localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // r0 and numbers beyond the file are never stored and always read zero.
  function automatic logic live(input logic [RW-1:0] num);
    return (num != '0) && (32'(num) < NREGS);
  endfunction

  assign ra_data_c  = live(ra_num)  ? mem_q[IW'(ra_num)]  : '0;
  assign rb_data_c  = live(rb_num)  ? mem_q[IW'(rb_num)]  : '0;
  assign dbg_data_c = live(dbg_num) ? mem_q[IW'(dbg_num)] : '0;

  always_comb begin
    mem_d = mem_q;
    if (we && live(wr_num)) begin
      mem_d[IW'(wr_num)] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue stage for an external alu32: operand read with forwarding, writeback, overflow trap.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  alu_issue_if.slave      io,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [CW-1:0]   alu_control,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  input  logic            alu_negative,
  output logic            halted,
  input  logic            clear,
  output logic [RCW-1:0]  retire_count,
  input  logic [RW-1:0]   dbg_num,
  output logic [XLEN-1:0] dbg_data
);

  issue_state_e    state_q, state_d;
  issue_t          iss_q, iss_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RW-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [FW-1:0]   wb_flags_q, wb_flags_d;
  logic [RCW-1:0]  retire_q, retire_d;
  logic            halted_q, halted_d;

  logic [XLEN-1:0] rs_data, rt_data, op_a, op_b, rt_fwd;
  logic            busy, trap, accept, fwd_ok, rf_we;

  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clk        (clock),
    .rst_n      (reset),
    .ra_num     (io.in_rs),
    .ra_data_c  (rs_data),
    .rb_num     (io.in_rt),
    .rb_data_c  (rt_data),
    .dbg_num    (dbg_num),
    .dbg_data_c (dbg_data),
    .we         (rf_we),
    .wr_num     (iss_q.rd),
    .wr_data    (alu_out)
  );

  assign busy   = (state_q == BUSY);
  assign trap   = busy && alu_overflow &&
                  ((iss_q.ctrl == CW'(ALU_ADD)) || (iss_q.ctrl == CW'(ALU_SUB)));
  assign rf_we  = busy && !trap;
  assign fwd_ok = rf_we && (iss_q.rd != '0);

  assign io.in_ready = reset && (state_q != HALT);
  assign accept      = io.in_valid && io.in_ready;

  // The in-flight result is written this edge, so the file still holds the stale value.
  always_comb begin
    op_a   = (fwd_ok && (iss_q.rd == io.in_rs)) ? alu_out : rs_data;
    rt_fwd = (fwd_ok && (iss_q.rd == io.in_rt)) ? alu_out : rt_data;
    op_b   = io.in_use_imm ? sext_imm(io.in_imm) : rt_fwd;
  end

  always_comb begin
    state_d    = state_q;
    iss_d      = iss_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;
    retire_d   = retire_q;

    if (busy) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = iss_q.rd;
      wb_data_d  = alu_out;
      wb_flags_d = trap ? FW'(3'b001) : {alu_negative, alu_zero, alu_overflow};
      if (!trap) begin
        retire_d = retire_q + RCW'(1);
      end
    end

    // A trap drops whatever was accepted on the same edge.
    if (accept && !trap) begin
      iss_d.a    = op_a;
      iss_d.b    = op_b;
      iss_d.ctrl = io.in_ctrl;
      iss_d.rd   = io.in_rd;
    end

    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY: begin
        if (trap)        state_d = HALT;
        else if (accept) state_d = BUSY;
        else             state_d = IDLE;
      end
      HALT:    if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      iss_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      retire_q   <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      iss_q      <= iss_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
    end
  end

  assign alu_A        = iss_q.a;
  assign alu_B        = iss_q.b;
  assign alu_control  = iss_q.ctrl;
  assign io.wb_valid  = wb_valid_q;
  assign io.wb_rd     = wb_rd_q;
  assign io.wb_data   = wb_data_q;
  assign io.wb_flags  = wb_flags_q;
  assign retire_count = retire_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: behavioural alu32 plus an in-order architectural model of the issue stage.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic        clock;
  logic        reset;
  logic        clear;
  logic [31:0] alu_A, alu_B, alu_out;
  logic [2:0]  alu_control;
  logic        alu_overflow, alu_zero, alu_negative;
  logic        halted;
  logic [15:0] retire_count;
  logic [4:0]  dbg_num;
  logic [31:0] dbg_data;

  alu_issue_if bus();

  alu_issue #(.NREGS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .io           (bus),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_control  (alu_control),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .halted       (halted),
    .clear        (clear),
    .retire_count (retire_count),
    .dbg_num      (dbg_num),
    .dbg_data     (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Returns {overflow, result}; overflow only reported for ADD/SUB.
  function automatic logic [32:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic [31:0] r;
    logic v;
    s = 0;
    v = 1'b0;
    r = '0;
    case (c)
      ALU_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = 32'(s);
        v = (s > S_MAX) || (s < S_MIN);
      end
      ALU_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = 32'(s);
        v = (s > S_MAX) || (s < S_MIN);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  always_comb {alu_overflow, alu_out} = alu_ref(alu_control, alu_A, alu_B);
  assign alu_zero     = (alu_out == 32'd0);
  assign alu_negative = alu_out[31];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural model: registers, halt flag, retire count, plus the one result in flight.
  logic [31:0] m_regs [32];
  bit          m_halted;
  logic [15:0] m_retire;
  bit          p_v, p_trap;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic [2:0]  p_flags;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_halted = 1'b0;
    m_retire = '0;
    p_v      = 1'b0;
    p_trap   = 1'b0;
  endtask

  // One clock: drive at negedge, step the model, compare just after the rising edge.
  task automatic cycle(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] ctrl, input bit ui, input logic [15:0] imm, input bit clr);
    bit          was_halted, ev;
    logic [4:0]  er;
    logic [31:0] ed, a, b;
    logic [2:0]  ef;
    logic [32:0] res;
    bus.in_valid   = v;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_rd      = rd;
    bus.in_ctrl    = ctrl;
    bus.in_use_imm = ui;
    bus.in_imm     = imm;
    clear          = clr;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_halted));
    check("halted", 32'(halted), 32'(m_halted));
    was_halted = m_halted;
    ev = p_v; er = p_rd; ed = p_data; ef = p_flags;
    if (p_v) begin
      if (p_trap) m_halted = 1'b1;
      else begin
        if (p_rd != 5'd0) m_regs[p_rd] = p_data;
        m_retire = 16'(m_retire + 16'd1);
      end
    end
    if (v && !was_halted && !(p_v && p_trap)) begin
      a       = m_regs[rs];
      b       = ui ? {{16{imm[15]}}, imm} : m_regs[rt];
      res     = alu_ref(ctrl, a, b);
      p_trap  = res[32];
      p_rd    = rd;
      p_data  = res[31:0];
      p_flags = res[32] ? 3'b001 : {res[31], res[31:0] == 32'd0, 1'b0};
      p_v     = 1'b1;
    end else begin
      p_v = 1'b0;
    end
    if (was_halted && clr) m_halted = 1'b0;
    @(posedge clock);
    #1;
    check("wb_valid", 32'(bus.wb_valid), 32'(ev));
    if (ev) begin
      check("wb_rd", 32'(bus.wb_rd), 32'(er));
      check("wb_data", bus.wb_data, ed);
      check("wb_flags", 32'(bus.wb_flags), 32'(ef));
    end
    check("retire_count", 32'(retire_count), 32'(m_retire));
    @(negedge clock);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] op);
    cycle(1'b1, rs, rt, rd, op, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic issue_imm(input logic [4:0] rd, input logic [4:0] rs, input logic [2:0] op, input logic [15:0] imm);
    cycle(1'b1, rs, 5'd0, rd, op, 1'b1, imm, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] n);
    dbg_num = n;
    #1;
    check(tag, dbg_data, m_regs[n]);
  endtask

  logic [2:0]  ops [6];
  logic [15:0] saved_retire;
  int          guard;

  initial begin
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND;
    ops[3] = ALU_OR;  ops[4] = ALU_NOR; ops[5] = ALU_XOR;
    reset = 1'b0;
    clear = 1'b0;
    dbg_num = '0;
    bus.in_valid = 1'b0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_ctrl = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_flags", 32'(bus.wb_flags), 32'd0);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);
    check("rst_alu_ctrl", 32'(alu_control), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retire", 32'(retire_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // ADDI r1=8 then dependent ADD r2=r1+r1 back-to-back.
    issue_imm(5'd1, 5'd0, ALU_ADD, 16'd8);
    issue(5'd2, 5'd1, 5'd1, ALU_ADD);
    check("addi_wb_data", bus.wb_data, 32'd8);
    idle(1);
    check("add_fwd_wb_data", bus.wb_data, 32'd16);
    dbg_num = 5'd2; #1;
    check("r2_value", dbg_data, 32'd16);
    check("retire_two", 32'(retire_count), 32'd2);

    // Write to r0 is reported but not stored.
    issue_imm(5'd0, 5'd0, ALU_ADD, 16'd5);
    idle(1);
    check("r0_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("r0_wb_rd", 32'(bus.wb_rd), 32'd0);
    dbg_num = 5'd0; #1;
    check("r0_stays_zero", dbg_data, 32'd0);

    // SUB to zero sets the zero flag only.
    issue(5'd5, 5'd1, 5'd1, ALU_SUB);
    idle(1);
    check("sub_wb_data", bus.wb_data, 32'd0);
    check("sub_wb_flags", 32'(bus.wb_flags), 32'b010);

    // Build r3=0x7fffffff by doubling, then ADD +2 traps.
    issue_imm(5'd10, 5'd0, ALU_ADD, 16'd1);
    for (int i = 0; i < 30; i++) issue(5'd10, 5'd10, 5'd10, ALU_ADD);
    issue_imm(5'd11, 5'd10, ALU_SUB, 16'd1);
    issue(5'd3, 5'd10, 5'd11, ALU_ADD);
    idle(1);
    dbg_num = 5'd3; #1;
    check("r3_max", dbg_data, 32'h7fff_ffff);
    saved_retire = m_retire;
    issue_imm(5'd4, 5'd3, ALU_ADD, 16'd2);
    issue_imm(5'd12, 5'd0, ALU_ADD, 16'd7);
    check("trap_wb_flags", 32'(bus.wb_flags), 32'b001);
    check("trap_halted", 32'(halted), 32'd1);
    check("trap_in_ready", 32'(bus.in_ready), 32'd0);
    check("trap_retire", 32'(retire_count), 32'(saved_retire));
    issue_imm(5'd12, 5'd0, ALU_ADD, 16'd9);
    dbg_num = 5'd4; #1;
    check("trap_r4_unchanged", dbg_data, 32'd0);
    dbg_num = 5'd12; #1;
    check("trap_drop_r12", dbg_data, 32'd0);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 16'd0, 1'b1);
    check("clear_halted", 32'(halted), 32'd0);
    issue_imm(5'd12, 5'd0, ALU_ADD, 16'd7);
    idle(1);
    dbg_num = 5'd12; #1;
    check("after_clear_r12", dbg_data, 32'd7);

    // Reset one cycle after accepting ADD r6.
    issue(5'd6, 5'd1, 5'd1, ALU_ADD);
    reset = 1'b0;
    @(posedge clock); #1;
    check("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    dbg_num = 5'd6; #1;
    check("midrst_r6", dbg_data, 32'd0);
    check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("midrst_halted", 32'(halted), 32'd0);

    // Randomized traffic with dense register reuse to hit forwarding and traps.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
            16'($urandom), ($urandom_range(0, 3) == 0));
      if ((i % 8) == 0) dbg_check("rand_dbg", 5'($urandom_range(0, 7)));
    end

    // Retire counter wrap.
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 16'd0, 1'b1);
    idle(2);
    guard = 0;
    while (m_retire != 16'hFFFE && guard < 70000) begin
      issue_imm(5'd7, 5'd0, ALU_ADD, 16'd1);
      guard++;
    end
    idle(1);
    check("retire_ffff", 32'(retire_count), 32'h0000_ffff);
    issue_imm(5'd7, 5'd0, ALU_ADD, 16'd1);
    idle(1);
    check("retire_wrap", 32'(retire_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers (r0 hardwired zero).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1, instruction handshake; transfer when both high at a clock edge.
REQ-005 SHALL have ports in_rs, in_rt, in_rd  input  5 each, source and destination register numbers.
REQ-006 SHALL have ports in_ctrl input 3 (ALU opcode), in_use_imm input 1, in_imm input 16 (sign-extended into B when in_use_imm=1).
REQ-007 SHALL have ports alu_A, alu_B output 32, alu_control output 3, driving the alu32 operand and control inputs.
REQ-008 SHALL have ports alu_out input 32, alu_overflow, alu_zero, alu_negative input 1 each, from alu32.
REQ-009 SHALL have ports wb_valid output 1, wb_rd output 5, wb_data output 32, wb_flags output 3 {negative, zero, overflow}.
REQ-010 SHALL have ports halted output 1, clear input 1, retire_count output 16.
REQ-011 SHALL have ports dbg_num input 5, dbg_data output 32, combinational register-file read for the bench.

Function
REQ-012 SHALL implement states IDLE (issue register empty), BUSY (issue register holds an instruction), HALT.
REQ-013 SHALL drive in_ready=1 in IDLE and BUSY, 0 in HALT (one instruction accepted per cycle, no bubbles).
REQ-014 SHALL, on accept, register operand A=R[in_rs], B=R[in_rt] or sext(in_imm), ctrl and rd into the issue register; alu_A/alu_B/alu_control driven only from that register.
REQ-015 SHALL forward alu_out into operand A and/or B when the issue register is valid, its rd equals the source number, rd!=0 and the write is not suppressed (REQ-018).
REQ-016 SHALL, at the edge ending a BUSY cycle, write alu_out to R[rd] (no write when rd=0) and register wb_valid=1, wb_rd, wb_data=alu_out, wb_flags for exactly one cycle; latency accept-edge to wb_valid = 2 edges.
REQ-017 SHALL transition IDLE->BUSY on accept; BUSY->BUSY on accept; BUSY->IDLE with no accept; BUSY->HALT on overflow trap.
REQ-018 SHALL treat alu_overflow=1 with ctrl ADD or SUB as a trap: register write suppressed, wb_valid=1 with wb_flags overflow bit set, state HALT, any same-edge accept discarded (in_ready was high but instruction is dropped and not counted).
REQ-019 SHALL hold halted=1 in HALT; clear=1 for one cycle in HALT SHALL return to IDLE; clear ignored in IDLE/BUSY.
REQ-020 SHALL increment retire_count on each non-trapping writeback, wrapping 0xFFFF->0x0000.
REQ-021 SHALL return dbg_data=0 for dbg_num=0; reads SHALL return pre-edge contents (write visible the cycle after the edge).
REQ-022 SHALL ignore alu_zero/alu_negative/alu_overflow except in BUSY.

Reset
REQ-023 SHALL, while reset=0, force state IDLE, all registers R[1..NREGS-1]=0, issue register invalid, alu_A=alu_B=0, alu_control=0, wb_valid=0, wb_rd=0, wb_data=0, wb_flags=0, halted=0, retire_count=0.
REQ-024 SHALL, on reset mid-operation, discard the in-flight instruction with no register write and no wb_valid pulse.
REQ-025 SHALL hold in_ready=0 while reset=0.

Structure
REQ-026 SHALL take ALU opcode constants (ADD, SUB, AND, OR, NOR, XOR) and state encodings from the shared ALU package/header used by alu32.
REQ-027 SHALL contain one sub-module, alu_regfile (NREGS x 32, two combinational read ports plus debug port, one write port, r0 zero); alu32 stays outside the block.

Verification
REQ-028 Reset, then ADDI r1=r0+8 (imm), ADD r2=r1+r1 back-to-back -> wb_data 8 then 16, dbg r2=16, retire_count=2.
REQ-029 Write r0 with imm 5 -> wb_valid=1, wb_rd=0, dbg r0 stays 0.
REQ-030 r3=0x7fffffff then ADD r4=r3+imm 2 -> overflow trap, wb_flags=3'b001, halted=1, in_ready=0, r4 unchanged, retire_count not incremented; clear -> IDLE, next ADD accepted.
REQ-031 SUB r5=r1-r1 (r1=8) -> wb_data 0, wb_flags zero bit set, no trap.
REQ-032 Assert reset one cycle after accepting ADD r6 -> no wb_valid, r6=0, state IDLE after release.
REQ-033 Preload retire_count to 0xFFFF via 65535 issues, one more -> retire_count=0.
